game_sequencer: RTL and testbench

//  Round/level sequencer for the frogger top. Consumes death/win collision flags and the

---
 rtl/game_sequencer_pkg.sv | 36 +++
 rtl/game_sequencer_if.sv | 27 ++
 rtl/game_sequencer_hold_timer.sv | 31 +++
 rtl/game_sequencer.sv | 125 ++++++++++++
 tb/tb_game_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and defaults for the frogger round/level sequencer.
// State encodings, field widths and the car speed mapping used by the top and display path.
package game_sequencer_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned HOLD_W  = 8;

  localparam int unsigned DEF_MAX_LEVEL   = 9;
  localparam int unsigned DEF_START_LIVES = 3;
  localparam int unsigned DEF_HOLD_FRAMES = 30;
  localparam int unsigned DEF_BASE_SPEED  = 1;
  localparam int unsigned DEF_MAX_SPEED   = 8;

  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_DIE_HOLD = 3'd1,
    ST_WIN_HOLD = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_OVER     = 3'd4
  } state_t;

  // Sum is formed one bit wider than the result so a high level cannot wrap before saturating.
  function automatic logic [SPEED_W-1:0] calc_speed(input logic [LEVEL_W-1:0] lvl,
                                                    input int unsigned base_spd,
                                                    input int unsigned max_spd);
    logic [SPEED_W:0] sum;
    sum = {1'b0, lvl} + 5'(base_spd);
    if (sum > 5'(max_spd)) begin
      return 4'(max_spd);
    end
    return sum[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Event inputs and round/level status outputs of the sequencer.
// master drives collisions/ticks/restart; slave (the sequencer) drives status.
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic               frame_tick;
  logic               death_collision;
  logic               win_collision;
  logic               restart_req;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic [SPEED_W-1:0] car_speed;
  logic               freeze;
  logic               round_reset;
  logic               game_over;

  modport master (
    output frame_tick, death_collision, win_collision, restart_req,
    input  level, lives, car_speed, freeze, round_reset, game_over
  );

  modport slave (
    input  frame_tick, death_collision, win_collision, restart_req,
    output level, lives, car_speed, freeze, round_reset, game_over
  );

endinterface

// File: rtl/game_sequencer_hold_timer.sv
// Counts frame_tick pulses while enabled; done pulses combinationally on the HOLD_FRAMES-th tick.
// Count clears whenever disabled or on done; no backpressure.
module game_sequencer_hold_timer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic frame_tick,
  output logic done
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [HOLD_W-1:0] cnt_q;

  assign done = en && frame_tick && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || done) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      cnt_q <= cnt_q + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round/level sequencer: owns level and lives, freezes play after a death or win, then pulses round_reset.
// round_reset one cycle after the terminal hold tick; all outputs registered, no backpressure.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int unsigned START_LIVES = DEF_START_LIVES,
  parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int unsigned BASE_SPEED  = DEF_BASE_SPEED,
  parameter int unsigned MAX_SPEED   = DEF_MAX_SPEED
) (
  input  logic        clk,
  input  logic        reset,
  game_sequencer_if.slave bus
);

  localparam logic [LEVEL_W-1:0] TOP_LEVEL  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] INIT_LIVES = LIVES_W'(START_LIVES);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SPEED_W-1:0] speed_q;
  logic               freeze_q;
  logic               round_reset_q;
  logic               game_over_q;
  logic               death_prev_q;
  logic               win_prev_q;
  logic               death_edge;
  logic               win_edge;
  logic               hold_en;
  logic               hold_done;

  assign death_edge = bus.death_collision && !death_prev_q;
  assign win_edge   = bus.win_collision && !win_prev_q;
  assign hold_en    = (state_q == ST_DIE_HOLD) || (state_q == ST_WIN_HOLD);

  game_sequencer_hold_timer #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (reset),
    .en         (hold_en),
    .frame_tick (bus.frame_tick),
    .done       (hold_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  // Win outranks death in the same cycle, so a simultaneous hit costs no life.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    case (state_q)
      ST_PLAY: begin
        if (win_edge) begin
          state_d = ST_WIN_HOLD;
          level_d = (level_q == TOP_LEVEL) ? '0 : level_q + LEVEL_W'(1);
        end else if (death_edge) begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_DIE_HOLD;
        end else if (bus.restart_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_DIE_HOLD, ST_WIN_HOLD: begin
        if (hold_done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_PLAY;
      end
      ST_OVER: begin
        lives_d = '0;
        if (bus.restart_req) begin
          state_d = ST_RELEASE;
          lives_d = INIT_LIVES;
          level_d = '0;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q       <= '0;
      lives_q       <= INIT_LIVES;
      speed_q       <= calc_speed('0, BASE_SPEED, MAX_SPEED);
      freeze_q      <= 1'b0;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
      death_prev_q  <= 1'b0;
      win_prev_q    <= 1'b0;
    end else begin
      level_q       <= level_d;
      lives_q       <= lives_d;
      speed_q       <= calc_speed(level_q, BASE_SPEED, MAX_SPEED);
      freeze_q      <= (state_d != ST_PLAY);
      round_reset_q <= (state_d == ST_RELEASE);
      game_over_q   <= (state_d == ST_OVER);
      death_prev_q  <= bus.death_collision;
      win_prev_q    <= bus.win_collision;
    end
  end

  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.car_speed   = speed_q;
  assign bus.freeze      = freeze_q;
  assign bus.round_reset = round_reset_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: expected round results queued at each event, checked at round_reset.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  localparam int HOLD = 4;

  typedef struct {
    int level;
    int lives;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   m_level;
  int   m_lives;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .MAX_LEVEL   (9),
    .START_LIVES (3),
    .HOLD_FRAMES (HOLD),
    .BASE_SPEED  (1),
    .MAX_SPEED   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_speed(input int lvl);
    return (lvl + 1 > 8) ? 8 : lvl + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push();
    exp_t e;
    e.level = m_level;
    e.lives = m_lives;
    sb_q.push_back(e);
  endtask

  // Called in the cycle round_reset is expected high.
  task automatic sb_release();
    exp_t e;
    check("rr_pulse", bus.round_reset, 1);
    check("rr_freeze", bus.freeze, 1);
    check("sb_depth", sb_q.size(), 1);
    e.level = -1;
    e.lives = -1;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check("rel_level", bus.level, e.level);
    check("rel_lives", bus.lives, e.lives);
    step();
    check("rr_single", bus.round_reset, 0);
    check("play_freeze", bus.freeze, 0);
    check("play_over", bus.game_over, 0);
    check("play_speed", bus.car_speed, exp_speed(e.level));
  endtask

  task automatic do_hold();
    for (int i = 0; i < HOLD; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      if (i < HOLD - 1) begin
        check("hold_rr", bus.round_reset, 0);
        check("hold_freeze", bus.freeze, 1);
        step();
        step();
      end
    end
    sb_release();
  endtask

  task automatic win_evt();
    bus.win_collision = 1'b1;
    step();
    bus.win_collision = 1'b0;
    m_level = (m_level == 9) ? 0 : m_level + 1;
    check("win_level", bus.level, m_level);
    check("win_freeze", bus.freeze, 1);
    sb_push();
    do_hold();
  endtask

  task automatic death_evt(input int hold_cyc);
    bus.death_collision = 1'b1;
    repeat (hold_cyc) step();
    bus.death_collision = 1'b0;
    m_lives--;
    check("death_lives", bus.lives, m_lives);
    check("death_freeze", bus.freeze, 1);
    if (m_lives > 0) begin
      check("death_over", bus.game_over, 0);
      sb_push();
      do_hold();
    end else begin
      check("over_flag", bus.game_over, 1);
    end
  endtask

  task automatic restart_evt();
    sb_push();
    bus.restart_req = 1'b1;
    step();
    bus.restart_req = 1'b0;
    sb_release();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    m_level = 0;
    m_lives = 3;
    sb_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_lives"}, bus.lives, 3);
    check({tag, "_freeze"}, bus.freeze, 0);
    check({tag, "_rr"}, bus.round_reset, 0);
    check({tag, "_over"}, bus.game_over, 0);
    check({tag, "_speed"}, bus.car_speed, 1);
  endtask

  initial begin
    int n;
    reset               = 1'b1;
    bus.frame_tick      = 1'b0;
    bus.death_collision = 1'b0;
    bus.win_collision   = 1'b0;
    bus.restart_req     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_level = 0;
    m_lives = 3;

    // Idle after reset
    repeat (100) step();
    check_reset_vals("idle");

    // Single win, then a manual restart in PLAY keeping level/lives
    win_evt();
    restart_evt();

    // Ten wins: saturation at 8 and wrap from 9 back to 0
    do_reset();
    for (int i = 0; i < 10; i++) win_evt();
    check("wrap_level", bus.level, 0);

    // Death held high counts once; run out of lives; restart from OVER
    death_evt(50);
    death_evt(1);
    death_evt(1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      bus.frame_tick = (i % 4 == 0);
      step();
      if (bus.round_reset) n++;
    end
    bus.frame_tick = 1'b0;
    check("over_no_rr", n, 0);
    check("over_lives", bus.lives, 0);
    check("over_freeze", bus.freeze, 1);
    check("over_hold", bus.game_over, 1);
    m_lives = 3;
    m_level = 0;
    restart_evt();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.round_reset) n++;
    end
    check("restart_single", n, 0);

    // Simultaneous win and death at one life
    death_evt(1);
    death_evt(1);
    bus.win_collision   = 1'b1;
    bus.death_collision = 1'b1;
    step();
    bus.win_collision   = 1'b0;
    bus.death_collision = 1'b0;
    m_level = m_level + 1;
    check("both_level", bus.level, m_level);
    check("both_lives", bus.lives, 1);
    check("both_over", bus.game_over, 0);
    check("both_freeze", bus.freeze, 1);
    sb_push();
    do_hold();

    // Async reset in the middle of a death hold
    do_reset();
    win_evt();
    bus.death_collision = 1'b1;
    step();
    bus.death_collision = 1'b0;
    check("mid_lives", bus.lives, 2);
    for (int i = 0; i < 2; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
    #3 reset = 1'b1;
    #1;
    check_reset_vals("async");
    step();
    reset   = 1'b0;
    m_level = 0;
    m_lives = 3;
    sb_q.delete();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      bus.frame_tick = (i % 3 == 0);
      step();
      if (bus.round_reset) n++;
    end
    bus.frame_tick = 1'b0;
    check("post_rst_no_rr", n, 0);
    check("post_rst_freeze", bus.freeze, 0);
    win_evt();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
